// File: rtl/parking_pkg.sv
// Shared types and constants for the multi-bay parking meter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: per-bay state encoding, seconds-per-minute constant and an
// all-ones helper used to build saturation limits for arbitrary widths.
package parking_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_PARKED = 2'b01,
      ST_DUE    = 2'b10
   } bay_st_t;

   localparam int         SEC_PER_MIN = 60;
   localparam logic [5:0] SEC_LAST    = 6'(SEC_PER_MIN - 1);

   // All-ones value of width w; saturation ceiling for a w-bit field.
   function automatic longint unsigned all_ones(input int w);
      return (64'd1 << w) - 64'd1;
   endfunction

endpackage

// File: rtl/bay_channel.sv
// One parking bay: occupancy FSM, mm:ss elapsed counter, rate latch, cost.
// Latency: state/counters update on the sampling edge; cost is combinational.
// Backpressure: none; payment is a single-cycle accept pulse from the top.
//
// Ports: clk, rst (sync, active-low), tick_1hz, occ (bay level), rate (cents
// per started minute), pay (accepted payment for this bay); outputs state,
// parked (PARKED or DUE), min/sec/cost (forced to 0 while IDLE).
// Optional: MULTI_BAY_GRACE_EN deducts GRACE_MIN free started-minutes.
module bay_channel
   import parking_pkg::*;
#(
   parameter int MIN_W     = 7,
   parameter int COST_W    = 14,
   parameter int GRACE_MIN = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick_1hz,
   input  logic              occ,
   input  logic [7:0]        rate,
   input  logic              pay,
   output logic [1:0]        state,
   output logic              parked,
   output logic [MIN_W-1:0]  min,
   output logic [5:0]        sec,
   output logic [COST_W-1:0] cost
);

   localparam int               PW      = MIN_W + 8;
   localparam logic [MIN_W-1:0] MIN_MAX = '1;
`ifdef MULTI_BAY_GRACE_EN
   localparam int GRACE = GRACE_MIN;
`else
   // Grace collapses to zero, leaving the plain started-minute formula.
   localparam int GRACE = GRACE_MIN * 0;
`endif

   bay_st_t          st_q, st_nx;
   logic [MIN_W-1:0] min_q;
   logic [5:0]       sec_q;
   logic [7:0]       rate_q;
   logic [PW-1:0]    started, billable, prod;
   logic [COST_W-1:0] cost_sat;

   // State register
   always_ff @(posedge clk) begin
      if (!rst) st_q <= ST_IDLE;
      else      st_q <= st_nx;
   end

   // Next-state logic; the unused 2'b11 encoding behaves as IDLE
   always_comb begin
      st_nx = st_q;
      case (st_q)
         ST_PARKED: if (!occ) st_nx = ST_DUE;
         ST_DUE:    if (pay)  st_nx = ST_IDLE;
         default:   if (occ)  st_nx = ST_PARKED;
      endcase
   end

   // Elapsed-time counters and rate latch. A tick coinciding with departure
   // is not counted because counting requires occ in PARKED.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sec_q  <= '0;
         min_q  <= '0;
         rate_q <= '0;
      end else begin
         case (st_q)
            ST_PARKED: begin
               if (occ && tick_1hz) begin
                  if (sec_q != SEC_LAST) begin
                     sec_q <= sec_q + 6'd1;
                  end else if (min_q != MIN_MAX) begin
                     sec_q <= '0;
                     min_q <= min_q + MIN_W'(1);
                  end
               end
            end
            ST_DUE: begin
               if (pay) begin
                  sec_q <= '0;
                  min_q <= '0;
               end
            end
            default: begin
               if (occ) begin
                  sec_q  <= '0;
                  min_q  <= '0;
                  rate_q <= rate;
               end
            end
         endcase
      end
   end

   // Cost: rate x started minutes in MIN_W+8 bits (max 255 * 2^MIN_W fits),
   // then clamp to the COST_W ceiling.
   always_comb begin
      started  = PW'(min_q) + PW'(sec_q != 6'd0);
      billable = (started > PW'(GRACE)) ? started - PW'(GRACE) : '0;
      prod     = PW'(rate_q) * billable;
      cost_sat = (64'(prod) > all_ones(COST_W)) ? COST_W'(all_ones(COST_W))
                                                 : COST_W'(prod);
   end

   // Output logic
   always_comb begin
      state  = st_q;
      parked = (st_q == ST_PARKED) || (st_q == ST_DUE);
      min    = parked ? min_q    : '0;
      sec    = parked ? sec_q    : '0;
      cost   = parked ? cost_sat : '0;
   end

endmodule

// File: rtl/multi_bay_meter.sv
// Multi-bay parking meter core: NUM_BAYS bay channels, display scanner, payment.
// Latency: disp_* and due_any registered (1 cycle behind bay state); pay_ready comb.
// Backpressure: pay_valid is accepted only while pay_ready; otherwise dropped.
//
// Ports: clk, rst (sync, active-low), tick_1hz, occ[NUM_BAYS], rate, pay_valid,
// pay_bay, pay_ready; bay_state (2 bits per bay), due_any, disp_bay,
// disp_parked, disp_min, disp_sec, disp_cost.
// Optional: MULTI_BAY_GRACE_EN enables GRACE_MIN free minutes in each bay.
module multi_bay_meter
   import parking_pkg::*;
#(
   parameter int NUM_BAYS  = 4,
   parameter int BAY_W     = 4,
   parameter int MIN_W     = 7,
   parameter int COST_W    = 14,
   parameter int DWELL_SEC = 3,
   parameter int GRACE_MIN = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tick_1hz,
   input  logic [NUM_BAYS-1:0]   occ,
   input  logic [7:0]            rate,
   input  logic                  pay_valid,
   input  logic [BAY_W-1:0]      pay_bay,
   output logic                  pay_ready,
   output logic [2*NUM_BAYS-1:0] bay_state,
   output logic                  due_any,
   output logic [BAY_W-1:0]      disp_bay,
   output logic                  disp_parked,
   output logic [MIN_W-1:0]      disp_min,
   output logic [5:0]            disp_sec,
   output logic [COST_W-1:0]     disp_cost
);

   localparam int DW_W = $clog2(DWELL_SEC + 1);

   logic [1:0]        st_v   [NUM_BAYS];
   logic [MIN_W-1:0]  min_v  [NUM_BAYS];
   logic [5:0]        sec_v  [NUM_BAYS];
   logic [COST_W-1:0] cost_v [NUM_BAYS];
   logic [NUM_BAYS-1:0] parked_v, due_v, pay_acc;

   logic [DW_W-1:0]   dwell_q, dwell_nx;
   logic [BAY_W-1:0]  sel_nx, due_low;
   logic              parked_nx;
   logic [MIN_W-1:0]  min_nx;
   logic [5:0]        sec_nx;
   logic [COST_W-1:0] cost_nx;

   for (genvar i = 0; i < NUM_BAYS; i++) begin : g_bay
      bay_channel #(
         .MIN_W     (MIN_W),
         .COST_W    (COST_W),
         .GRACE_MIN (GRACE_MIN)
      ) u_bay (
         .clk      (clk),
         .rst      (rst),
         .tick_1hz (tick_1hz),
         .occ      (occ[i]),
         .rate     (rate),
         .pay      (pay_acc[i]),
         .state    (st_v[i]),
         .parked   (parked_v[i]),
         .min      (min_v[i]),
         .sec      (sec_v[i]),
         .cost     (cost_v[i])
      );
      assign bay_state[2*i+1:2*i] = st_v[i];
      assign due_v[i]             = (st_v[i] == ST_DUE);
   end

   // Payment decode: out-of-range indices never match, so they are dropped.
   always_comb begin
      pay_ready = 1'b0;
      pay_acc   = '0;
      for (int i = 0; i < NUM_BAYS; i++) begin
         if (pay_bay == BAY_W'(i) && due_v[i]) begin
            pay_ready  = 1'b1;
            pay_acc[i] = pay_valid;
         end
      end
   end

   // Scanner: a DUE bay pins the display and restarts the dwell so normal
   // rotation resumes from that bay with a full dwell after payment.
   always_comb begin
      sel_nx   = disp_bay;
      dwell_nx = dwell_q;
      due_low  = '0;
      for (int i = NUM_BAYS - 1; i >= 0; i--) begin
         if (due_v[i]) due_low = BAY_W'(i);
      end
      if (|due_v) begin
         sel_nx   = due_low;
         dwell_nx = '0;
      end else if (tick_1hz) begin
         if (dwell_q == DW_W'(DWELL_SEC - 1)) begin
            dwell_nx = '0;
            sel_nx   = (disp_bay == BAY_W'(NUM_BAYS - 1)) ? '0
                                                          : disp_bay + BAY_W'(1);
         end else begin
            dwell_nx = dwell_q + DW_W'(1);
         end
      end
   end

   // Display mux keyed on the next selection so disp_bay and its data agree.
   always_comb begin
      parked_nx = 1'b0;
      min_nx    = '0;
      sec_nx    = '0;
      cost_nx   = '0;
      for (int i = 0; i < NUM_BAYS; i++) begin
         if (sel_nx == BAY_W'(i)) begin
            parked_nx = parked_v[i];
            min_nx    = min_v[i];
            sec_nx    = sec_v[i];
            cost_nx   = cost_v[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         dwell_q     <= '0;
         disp_bay    <= '0;
         due_any     <= 1'b0;
         disp_parked <= 1'b0;
         disp_min    <= '0;
         disp_sec    <= '0;
         disp_cost   <= '0;
      end else begin
         dwell_q     <= dwell_nx;
         disp_bay    <= sel_nx;
         due_any     <= |due_v;
         disp_parked <= parked_nx;
         disp_min    <= min_nx;
         disp_sec    <= sec_nx;
         disp_cost   <= cost_nx;
      end
   end

endmodule

// File: tb/tb_multi_bay_meter.sv
// Directed bench for multi_bay_meter with default parameters.
module tb_multi_bay_meter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        tick_1hz = 1'b0;
   logic [3:0]  occ = '0;
   logic [7:0]  rate = '0;
   logic        pay_valid = 1'b0;
   logic [3:0]  pay_bay = '0;
   logic        pay_ready;
   logic [7:0]  bay_state;
   logic        due_any;
   logic [3:0]  disp_bay;
   logic        disp_parked;
   logic [6:0]  disp_min;
   logic [5:0]  disp_sec;
   logic [13:0] disp_cost;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef MULTI_BAY_GRACE_EN
   localparam int GR = 2;
`else
   localparam int GR = 0;
`endif

   multi_bay_meter #(
      .NUM_BAYS(4), .BAY_W(4), .MIN_W(7), .COST_W(14), .DWELL_SEC(3), .GRACE_MIN(2)
   ) dut (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .occ(occ), .rate(rate),
      .pay_valid(pay_valid), .pay_bay(pay_bay), .pay_ready(pay_ready),
      .bay_state(bay_state), .due_any(due_any), .disp_bay(disp_bay),
      .disp_parked(disp_parked), .disp_min(disp_min), .disp_sec(disp_sec),
      .disp_cost(disp_cost)
   );

   always #5 clk = ~clk;

   // Expected cost: rate x billable started minutes, clamped to 14 bits.
   function automatic int exp_cost(input int r, input int started);
      int b;
      int c;
      b = (started > GR) ? started - GR : 0;
      c = r * b;
      return (c > 16383) ? 16383 : c;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      tick_1hz = 1'b1;
      repeat (n) step();
      tick_1hz = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_state"},  bay_state,   0);
      chk({tag, "_due"},    due_any,     0);
      chk({tag, "_ready"},  pay_ready,   0);
      chk({tag, "_bay"},    disp_bay,    0);
      chk({tag, "_parked"}, disp_parked, 0);
      chk({tag, "_min"},    disp_min,    0);
      chk({tag, "_sec"},    disp_sec,    0);
      chk({tag, "_cost"},   disp_cost,   0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      step(); step();
      chk_reset_outputs("rst0");
      rst = 1'b1;

      // Bay 0: 125 s at 25 c/min -> 2:05, 3 started minutes
      rate = 8'd25; occ[0] = 1'b1;
      step();
      chk("b0_parked", bay_state[1:0], 2'b01);
      ticks(125);
      occ[0] = 1'b0;
      step();
      chk("b0_due", bay_state[1:0], 2'b10);
      step();
      chk("b0_due_any", due_any, 1);
      chk("b0_disp_bay", disp_bay, 0);
      chk("b0_disp_parked", disp_parked, 1);
      chk("b0_min", disp_min, 2);
      chk("b0_sec", disp_sec, 5);
      chk("b0_cost", disp_cost, exp_cost(25, 3));
      pay_bay = 4'd0; pay_valid = 1'b1; #1;
      chk("b0_ready", pay_ready, 1);
      step(); pay_valid = 1'b0;
      chk("b0_paid", bay_state[1:0], 2'b00);

      // Bay 1: single-cycle occ pulse -> DUE with zero cost; payment rules
      occ[1] = 1'b1; step(); occ[1] = 1'b0; step();
      chk("b1_due", bay_state[3:2], 2'b10);
      step();
      chk("b1_disp_bay", disp_bay, 1);
      chk("b1_cost0", disp_cost, 0);
      pay_bay = 4'd1; pay_valid = 1'b1; #1;
      chk("b1_ready", pay_ready, 1);
      step();
      chk("b1_idle", bay_state[3:2], 2'b00);
      chk("b1_repay_ready", pay_ready, 0);
      step();
      chk("b1_repay_nochange", bay_state, 8'h00);
      pay_valid = 1'b0;
      // Bay 3 DUE, then a payment to out-of-range bay 15 must not touch it
      occ[3] = 1'b1; step(); occ[3] = 1'b0; step();
      pay_bay = 4'd15; pay_valid = 1'b1; #1;
      chk("oor_ready", pay_ready, 0);
      step();
      chk("oor_dropped", bay_state[7:6], 2'b10);
      pay_bay = 4'd3; step(); pay_valid = 1'b0;
      chk("b3_paid", bay_state[7:6], 2'b00);

      // Scanner rotation with bays 0 and 2 parked
      rst = 1'b0; step(); rst = 1'b1;
      rate = 8'd10; occ = 4'b0101;
      step();
      chk("scan_parked", bay_state, 8'h11);
      for (int k = 1; k <= 12; k++) begin
         tick_1hz = 1'b1; step(); tick_1hz = 1'b0;
         chk($sformatf("scan_k%0d", k), disp_bay, (k / 3) % 4);
         step();
      end
      occ[2] = 1'b0; step(); step();
      chk("lock_bay", disp_bay, 2);
      chk("lock_due_any", due_any, 1);
      chk("lock_sec", disp_sec, 12);
      chk("lock_cost", disp_cost, exp_cost(10, 1));
      ticks(6);
      chk("lock_hold_bay", disp_bay, 2);
      chk("lock_frozen_sec", disp_sec, 12);
      pay_bay = 4'd2; pay_valid = 1'b1; step(); pay_valid = 1'b0;
      chk("b2_paid", bay_state[5:4], 2'b00);
      step();
      chk("unlock_due_any", due_any, 0);
      chk("unlock_bay", disp_bay, 2);
      ticks(3);
      chk("resume_bay", disp_bay, 3);

      // Bay 3 held occupied through DUE and payment -> re-park with new rate
      occ[3] = 1'b1; step();
      ticks(5);
      occ[3] = 1'b0; step();
      occ[3] = 1'b1; step();
      chk("b3_occ_ignored", bay_state[7:6], 2'b10);
      rate = 8'd40; pay_bay = 4'd3; pay_valid = 1'b1; #1;
      chk("b3_ready", pay_ready, 1);
      step(); pay_valid = 1'b0;
      chk("b3_idle_1cyc", bay_state[7:6], 2'b00);
      step();
      chk("b3_reparked", bay_state[7:6], 2'b01);
      step();
      chk("b3_disp_bay", disp_bay, 3);
      chk("b3_min0", disp_min, 0);
      chk("b3_sec0", disp_sec, 0);
      chk("b3_cost0", disp_cost, 0);
      ticks(1); step();
      chk("b3_sec1", disp_sec, 1);
      chk("b3_rate_relatched", disp_cost, exp_cost(40, 1));

      // Counter and cost saturation on bay 1
      occ = '0; rate = 8'd255;
      rst = 1'b0; step(); rst = 1'b1;
      occ[1] = 1'b1; step();
      ticks(7700);
      occ[1] = 1'b0; step(); step();
      chk("sat_bay", disp_bay, 1);
      chk("sat_min", disp_min, 127);
      chk("sat_sec", disp_sec, 59);
      chk("sat_cost", disp_cost, exp_cost(255, 128));

      // Reset mid-operation with one bay PARKED and one DUE
      occ[0] = 1'b1; step();
      ticks(10);
      chk("pre_rst_state", bay_state, 8'h09);
      pay_bay = 4'd1; #1;
      chk("pre_rst_ready", pay_ready, 1);
      rst = 1'b0; step();
      chk_reset_outputs("rst1");
      rst = 1'b1; step();
      chk("post_rst_repark", bay_state, 8'h01);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/multi_bay_meter.md
# multi_bay_meter

Parametrised multi-bay parking meter core: tracks NUM_BAYS spaces at once, each with its own occupancy state machine, elapsed-time counter, latched rate and cost. Replaces the single-space counter/cost path between the sensor front end and the seven-segment display driver. A round-robin scanner selects which bay's time or cost goes to the display path. A payment handshake releases each bay's final charge.

## Interface
- NUM_BAYS, 4: number of bays (1..16)
- BAY_W, 4: bay index width, ≥ clog2(NUM_BAYS), min 1
- MIN_W, 7: minute counter width; elapsed time saturates at 2^MIN_W−1 min 59 s
- COST_W, 14: cost width in cents; saturates at 2^COST_W−1
- DWELL_SEC, 3: display dwell per bay in seconds (≥1)
- GRACE_MIN, 2: free started-minutes, used only with MULTI_BAY_GRACE_EN
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- tick_1hz  in  1  one-cycle enable, once per second
- occ  in  NUM_BAYS  debounced occupancy level per bay, 1 = car present
- rate  in  8  cents per started minute; sampled per bay on arrival
- pay_valid  in  1  payment request for bay pay_bay
- pay_bay  in  BAY_W  bay being paid
- pay_ready  out  1  addressed bay is DUE; a payment is accepted on pay_valid && pay_ready
- bay_state  out  2*NUM_BAYS  packed per-bay state; bay i occupies bits [2i+1:2i]
- due_any  out  1  OR of all bays in DUE
- disp_bay  out  BAY_W  bay currently shown
- disp_parked  out  1  shown bay is PARKED or DUE; 1 = cost mode, 0 = time mode
- disp_min  out  MIN_W  shown bay's whole minutes
- disp_sec  out  6  shown bay's seconds, 0..59
- disp_cost  out  COST_W  shown bay's cost in cents

## Operation
- Per-bay FSM with states IDLE, PARKED and DUE.
  - IDLE → PARKED when occ[i]=1. Clears sec/min to 0 and latches rate into rate_q[i].
  - PARKED: each tick_1hz advances sec. At 59, sec wraps to 0 and min increments. At max min and 59 s the counter holds.
  - PARKED → DUE when occ[i]=0. The tick in the same cycle is not counted. Counters and cost freeze.
  - DUE → IDLE on an accepted payment to bay i. Counters clear.
  - occ[i]=1 while in DUE is ignored. If occ is still 1 after payment, the bay enters PARKED on the following cycle.
- Cost per bay:
  - started = min + (sec≠0)
  - cost = rate_q × started, saturated to COST_W
  - Arithmetic is done at MIN_W+8 bits before saturation.
- pay_ready = (pay_bay < NUM_BAYS) && state[pay_bay]==DUE.
  - pay_valid without pay_ready is dropped with no effect.
  - Only one bay is paid per cycle.
- Scanner:
  - Dwell counter counts ticks. After DWELL_SEC ticks, disp_bay advances to the next index, wrapping NUM_BAYS−1 → 0.
  - If due_any=1, the scanner skips to and stays on the lowest-index DUE bay until that bay is paid.
- disp_* mirror the selected bay. In IDLE the bay shows 0:00 and cost 0.
- Reset mid-operation discards all bay state; no charge is retained.

## Timing
- Reset values: all bays IDLE, counters 0, rate_q 0, bay_state 0, due_any 0, pay_ready 0, disp_bay 0, disp_parked 0, disp_min 0, disp_sec 0, disp_cost 0, dwell counter 0.
- State and counters update on the clk edge where the condition is sampled.
- disp_* and due_any are registered, lagging internal state by 1 cycle.
- pay_ready is combinational from pay_bay and registered state, so it is valid the same cycle.
- Cost is visible on disp_cost 1 cycle after the counter update that changes it.
- The IDLE → PARKED → DUE sequence needs at least 2 cycles. An occ pulse of 1 cycle gives DUE with cost 0.

## Configuration
- MULTI_BAY_GRACE_EN defined: cost = rate_q × max(0, started − GRACE_MIN). A bay that leaves within GRACE_MIN minutes enters DUE with cost 0 and still requires payment/ack.
- MULTI_BAY_GRACE_EN undefined: no grace, the formula above applies, and GRACE_MIN is unused.

## Structure
- Package parking_pkg:
  - bay_state encoding: IDLE=2'b00, PARKED=2'b01, DUE=2'b10 (2'b11 unused; treated as IDLE)
  - SEC_PER_MIN=60
  - saturation helper constants
- Sub-module bay_channel: one FSM, sec/min counters, rate latch and cost multiply/saturate. It is instantiated NUM_BAYS times in a generate loop.
- The top level holds the scanner, DUE priority select, payment decode and output registers.

## Test plan
- Reset, then occ[0]=1 and 125 ticks, then occ[0]=0 with rate=25. Expect bay 0 DUE, min=2, sec=5, disp_cost=75. Expect 25 with MULTI_BAY_GRACE_EN and GRACE_MIN=2.
- Bay 1 DUE, then pay_valid with pay_bay=1 → pay_ready=1 and bay 1 goes to IDLE next cycle. Then pay_bay=1 again → pay_ready=0 and no change. Then pay_bay=15 with NUM_BAYS=4 → dropped.
- Bays 0 and 2 parked, no DUE, DWELL_SEC=3, over 12 ticks → disp_bay steps 0,1,2,3,0 every 3 ticks. When bay 2 leaves, disp_bay locks to 2 until it is paid.
- Bay 3 in DUE while occ[3] is held at 1, then paid → IDLE for 1 cycle, then PARKED with 0:00 and rate re-latched.
- MIN_W=2, rate=255, park 300 s → min holds at 3 and sec at 59. Cost = 255×4 = 1020, which is not saturated. COST_W=8 → 255.
- Assert rst=0 while bays are PARKED and DUE, mid-count → all outputs at their reset values on the next cycle. Assert rst=1 → bays re-enter PARKED from occ.
